// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI4-Lite register file:
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_t              : write-channel FSM states
//   rd_state_t              : read-channel FSM states
// No ports (package).
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
// Register storage behind the AXI4-Lite responder.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   we                commit strobe (one write per asserted cycle)
//   wr_idx            register index to commit
//   wr_data, wr_strb  write data and byte-lane enables
//   rd_idx / rd_data  combinational read port (returns pre-edge contents)
//   regs_flat         all registers, reg i at [i*WIDTH +: WIDTH]
//   wr_pulse          bit i high the cycle after reg i was committed
// ---------------------------------------------------------------------------
module axi_lite_regbank
    import axi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDXW-1:0]        wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [WIDTH/8-1:0]     wr_strb,
    input  logic [IDXW-1:0]        rd_idx,
    output logic [WIDTH-1:0]       rd_data,
    output logic [NREGS*WIDTH-1:0] regs_flat,
    output logic [NREGS-1:0]       wr_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [WIDTH-1:0] value_reg;
            logic             pulse_reg;
            logic             hit;

            assign hit = we && (wr_idx == IDXW'(gi));

            // A commit with all strobes low still produces a pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    for (int b = 0; b < WIDTH / 8; b++) begin
                        if (hit && wr_strb[b]) begin
                            value_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign regs_flat[gi*WIDTH +: WIDTH] = value_reg;
            assign wr_pulse[gi]                 = pulse_reg;
        end
    endgenerate

    assign rd_data = regs_flat[rd_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
// AXI4-Lite responder backed by NREGS software-visible registers.
// Independent write (AW+W -> B) and read (AR -> R) state machines; AW and W
// may arrive in either order or together.
// Ports:
//   ACLK, ARESETn                       clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY              write address channel
//   WDATA/WSTRB/WVALID/WREADY           write data channel
//   BRESP/BVALID/BREADY                 write response channel
//   ARADDR/ARVALID/ARREADY              read address channel
//   RDATA/RRESP/RVALID/RREADY           read data channel
//   regs_out                            flat register export
//   wr_pulse                            per-register commit strobe
// Build option: define AXI_REGFILE_SLVERR_EN to answer out-of-range accesses
// with SLVERR; otherwise they are answered OKAY. Either way such writes are
// dropped and such reads return zero.
// ---------------------------------------------------------------------------
module axi_lite_regfile
    import axi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [WIDTH-1:0]       AWADDR,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [WIDTH-1:0]       WDATA,
    input  logic [WIDTH/8-1:0]     WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [WIDTH-1:0]       ARADDR,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [WIDTH-1:0]       RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output logic [NREGS-1:0]       wr_pulse
);

    localparam int STRBW = WIDTH / 8;
    localparam int ABITS = $clog2(STRBW);
    localparam int IDXW  = $clog2(NREGS);

`ifdef AXI_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    // ---------------- write path ----------------
    wr_state_t        wr_state_reg, wr_state_next;
    logic             awready_reg, awready_next;
    logic             wready_reg, wready_next;
    logic             aw_held_reg, aw_held_next;
    logic             w_held_reg, w_held_next;
    logic [WIDTH-1:0] awaddr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [STRBW-1:0] wstrb_reg;
    logic [1:0]       bresp_reg, bresp_next;

    logic             aw_hs, w_hs, commit;
    logic [WIDTH-1:0] cur_awaddr, cur_wdata, wr_idx_full;
    logic [STRBW-1:0] cur_wstrb;
    logic             wr_in_range;

    assign aw_hs = AWVALID && awready_reg;
    assign w_hs  = WVALID && wready_reg;

    // A channel handshaking on the commit edge is used directly, not via its latch.
    assign cur_awaddr  = aw_hs ? AWADDR : awaddr_reg;
    assign cur_wdata   = w_hs ? WDATA : wdata_reg;
    assign cur_wstrb   = w_hs ? WSTRB : wstrb_reg;
    assign wr_idx_full = cur_awaddr >> ABITS;
    assign wr_in_range = wr_idx_full < WIDTH'(NREGS);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_reg <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            bresp_reg    <= bresp_next;
            if (aw_hs) awaddr_reg <= AWADDR;
            if (w_hs) begin
                wdata_reg <= WDATA;
                wstrb_reg <= WSTRB;
            end
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        aw_held_next  = aw_held_reg;
        w_held_next   = w_held_reg;
        bresp_next    = bresp_reg;
        commit        = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if ((aw_hs || aw_held_reg) && (w_hs || w_held_reg)) begin
                    commit        = 1'b1;
                    wr_state_next = W_RESP;
                    awready_next  = 1'b0;
                    wready_next   = 1'b0;
                    aw_held_next  = 1'b0;
                    w_held_next   = 1'b0;
                    bresp_next    = wr_in_range ? RESP_OKAY : OOR_RESP;
                end else begin
                    aw_held_next = aw_held_reg || aw_hs;
                    w_held_next  = w_held_reg || w_hs;
                    awready_next = !(aw_held_reg || aw_hs);
                    wready_next  = !(w_held_reg || w_hs);
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_next = W_IDLE;
                    awready_next  = 1'b1;
                    wready_next   = 1'b1;
                end
            end
        endcase
    end

    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = (wr_state_reg == W_RESP);
    assign BRESP   = bresp_reg;

    // ---------------- read path ----------------
    rd_state_t        rd_state_reg, rd_state_next;
    logic             arready_reg, arready_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]       rresp_reg, rresp_next;

    logic             ar_hs, rd_in_range;
    logic [WIDTH-1:0] rd_idx_full, bank_rd_data;

    assign ar_hs       = ARVALID && arready_reg;
    assign rd_idx_full = ARADDR >> ABITS;
    assign rd_in_range = rd_idx_full < WIDTH'(NREGS);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_reg <= R_IDLE;
            arready_reg  <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            arready_reg  <= arready_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        arready_next  = arready_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;
        case (rd_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (ar_hs) begin
                    rd_state_next = R_DATA;
                    arready_next  = 1'b0;
                    // Bank read is combinational, so a commit on this edge is not yet visible.
                    rdata_next    = rd_in_range ? bank_rd_data : '0;
                    rresp_next    = rd_in_range ? RESP_OKAY : OOR_RESP;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_next = R_IDLE;
                    arready_next  = 1'b1;
                end
            end
        endcase
    end

    assign ARREADY = arready_reg;
    assign RVALID  = (rd_state_reg == R_DATA);
    assign RDATA   = rdata_reg;
    assign RRESP   = rresp_reg;

    // ---------------- storage ----------------
    axi_lite_regbank #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_bank (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .we        (commit && wr_in_range),
        .wr_idx    (wr_idx_full[IDXW-1:0]),
        .wr_data   (cur_wdata),
        .wr_strb   (cur_wstrb),
        .rd_idx    (rd_idx_full[IDXW-1:0]),
        .rd_data   (bank_rd_data),
        .regs_flat (regs_out),
        .wr_pulse  (wr_pulse)
    );

endmodule

// File: tb/tb_axi_lite_regfile.sv
`timescale 1ns/1ps
module tb_axi_lite_regfile;

    localparam int WIDTH = 32;
    localparam int NREGS = 8;

`ifdef AXI_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic [WIDTH-1:0]       AWADDR;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [WIDTH-1:0]       WDATA;
    logic [WIDTH/8-1:0]     WSTRB;
    logic                   WVALID;
    logic                   WREADY;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;
    logic [WIDTH-1:0]       ARADDR;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [WIDTH-1:0]       RDATA;
    logic [1:0]             RRESP;
    logic                   RVALID;
    logic                   RREADY;
    logic [NREGS*WIDTH-1:0] regs_out;
    logic [NREGS-1:0]       wr_pulse;

    always #5 ACLK = ~ACLK;

    axi_lite_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [NREGS];
    logic [1:0]  bq [$];
    rexp_t       rq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NREGS; i++)
            check($sformatf("regs_out[%0d]", i), regs_out[i*WIDTH +: WIDTH], model[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 0);
        check({tag, "_rdata"}, RDATA, 0);
        check({tag, "_wr_pulse"}, wr_pulse, 0);
        check({tag, "_regs_out"}, regs_out, 0);
    endtask

    // Scoreboard monitor: compares every response handshake against the queue.
    always @(negedge ACLK) begin : monitor
        logic [1:0] be;
        rexp_t      re;
        if (ARESETn === 1'b1) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    be = bq.pop_front();
                    check("bresp", BRESP, be);
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    re = rq.pop_front();
                    check("rdata", RDATA, re.data);
                    check("rresp", RRESP, re.resp);
                end
            end
        end
    end

    task automatic wait_b();
        bit hs = 0;
        BREADY = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge ACLK);
            hs = BVALID && BREADY;
            @(posedge ACLK); #1;
        end
        BREADY = 1'b0;
        if (!hs) check("b_handshake_timeout", 0, 1);
    endtask

    task automatic wait_r();
        bit hs = 0;
        RREADY = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge ACLK);
            hs = RVALID && RREADY;
            @(posedge ACLK); #1;
        end
        RREADY = 1'b0;
        if (!hs) check("r_handshake_timeout", 0, 1);
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdelay);
        int aw_at, w_at, cyc, idx;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [NREGS-1:0] exp_pulse;
        logic [1:0] exp_resp;
        aw_at = (lead > 0) ? lead : 0;
        w_at  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            AWADDR  = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && (cyc >= aw_at);
            WVALID  = !w_done && (cyc >= w_at);
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        if (!(aw_done && w_done)) begin
            check("write_handshake_timeout", 0, 1);
            return;
        end
        idx = idx_of(a);
        exp_pulse = '0;
        exp_resp  = OOR;
        if (idx < NREGS) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            exp_pulse[idx] = 1'b1;
            exp_resp = 2'b00;
        end
        bq.push_back(exp_resp);
        $display("write addr=%h data=%h strb=%h lead=%0d resp_exp=%b", a, d, s, lead, exp_resp);
        check("bvalid_latency", BVALID, 1);
        check("wr_pulse", wr_pulse, exp_pulse);
        check_regs();
        for (int c = 0; c < bdelay; c++) begin
            @(posedge ACLK); #1;
            check("bvalid_hold", {BVALID, BRESP}, {1'b1, exp_resp});
            check("wr_pulse_one_cycle", wr_pulse, 0);
        end
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay);
        bit hs = 0;
        int idx;
        rexp_t re;
        ARADDR = a;
        for (int c = 0; c < 50 && !hs; c++) begin
            ARVALID = 1'b1;
            @(negedge ACLK);
            hs = ARVALID && ARREADY;
            @(posedge ACLK); #1;
        end
        ARVALID = 1'b0;
        if (!hs) begin
            check("ar_handshake_timeout", 0, 1);
            return;
        end
        idx = idx_of(a);
        re.data = (idx < NREGS) ? model[idx] : 32'h0;
        re.resp = (idx < NREGS) ? 2'b00 : OOR;
        rq.push_back(re);
        $display("read  addr=%h data_exp=%h resp_exp=%b rdelay=%0d", a, re.data, re.resp, rdelay);
        check("rvalid_latency", RVALID, 1);
        for (int c = 0; c < rdelay; c++) begin
            @(posedge ACLK); #1;
            check("r_hold", {RVALID, ARREADY, RRESP, RDATA}, {1'b1, 1'b0, re.resp, re.data});
        end
        wait_r();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a;
        rexp_t re;
        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
        BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("readies_low_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        check("readies_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Same-cycle AW/W, then W-before-AW partial strobe merge.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 1);
        check("reg1_value", regs_out[1*WIDTH +: WIDTH], 32'hDEADBEEF);
        do_write(32'h08, 32'h11223344, 4'hF, 0, 0);
        do_write(32'h08, 32'h000000AA, 4'h1, 3, 0);
        check("reg2_merge", regs_out[2*WIDTH +: WIDTH], 32'h112233AA);
        do_write(32'h14, 32'hCAFEF00D, 4'h0, -2, 0);

        // Read with back-pressure.
        do_read(32'h04, 4);

        // Write commit and read capture on the same edge to reg3.
        AWADDR = 32'h0C; WDATA = 32'h55; WSTRB = 4'hF; ARADDR = 32'h0C;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(negedge ACLK);
        check("same_edge_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        re.data = model[3]; re.resp = 2'b00;
        rq.push_back(re);
        model[3] = 32'h55;
        bq.push_back(2'b00);
        $display("same-edge write/read reg3 old=%h new=%h", re.data, model[3]);
        check("same_edge_valids", {BVALID, RVALID}, 2'b11);
        check("same_edge_wr_pulse", wr_pulse, 8'h08);
        BREADY = 1; RREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0; RREADY = 0;
        check("same_edge_done", {BVALID, RVALID}, 2'b00);
        do_read(32'h0C, 0);

        // Out of range.
        do_write(32'h40, 32'h12345678, 4'hF, 0, 0);
        do_read(32'h40, 1);

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, NREGS + 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 2)));
            else
                do_read(a, int'($urandom_range(0, 2)));
        end

        // Reset while a write response is pending.
        AWADDR = 32'h10; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        check("bvalid_before_reset", BVALID, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        $display("reset asserted with BVALID pending");
        check_reset_outputs("midreset");
        @(negedge ACLK);
        ARESETn = 1'b1;
        BREADY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge ACLK); #1;
            check("no_bvalid_after_reset", BVALID, 0);
        end
        BREADY = 1'b0;
        do_read(32'h04, 0);

        repeat (3) @(posedge ACLK);
        #1;
        check("b_queue_drained", bq.size(), 0);
        check("r_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
